// File: rtl/logic_arbiter.sv
// Two-requester round-robin front end sharing one bitwise logic unit.
// One operation in flight: accept, one execute cycle, then hold the result until consumed.
//
// state | meaning
// IDLE  | arbitrate; ready asserted for the granted, valid requester
// EXEC  | compute from latched operands, load result registers
// RESP  | res_valid high, result held until res_ready
module logic_arbiter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [1:0]       req0_op,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [1:0]       req1_op,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic             res_id,
    output logic             res_zero
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic             last_grant;
    logic             grant_vld;
    logic             grant_id;
    logic             accept;
    logic [WIDTH-1:0] op_a, op_b;
    logic [1:0]       op_code;
    logic             op_id;
    logic [WIDTH-1:0] alu;

    // A tie goes to whoever was not granted last.
    always_comb begin
        grant_vld = 1'b0;
        grant_id  = 1'b0;
        if (req0_valid && req1_valid) begin
            grant_vld = 1'b1;
            grant_id  = ~last_grant;
        end else if (req0_valid) begin
            grant_vld = 1'b1;
            grant_id  = 1'b0;
        end else if (req1_valid) begin
            grant_vld = 1'b1;
            grant_id  = 1'b1;
        end
    end

    assign accept = (state == IDLE) && grant_vld;

    always_comb begin
        case (op_code)
            2'b00:   alu = op_a & op_b;
            2'b01:   alu = op_a | op_b;
            2'b10:   alu = op_a ^ op_b;
            default: alu = ~op_a;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = IDLE;
        case (state)
            IDLE:    state_nxt = grant_vld ? EXEC : IDLE;
            EXEC:    state_nxt = RESP;
            RESP:    state_nxt = res_ready ? IDLE : RESP;
            default: state_nxt = IDLE;
        endcase
    end

    // Ready is gated by rst_n so it stays low while reset is held.
    always_comb begin
        req0_ready = rst_n && accept && (grant_id == 1'b0);
        req1_ready = rst_n && accept && (grant_id == 1'b1);
        res_valid  = (state == RESP);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= 1'b1;
            op_a       <= '0;
            op_b       <= '0;
            op_code    <= 2'b00;
            op_id      <= 1'b0;
            res_data   <= '0;
            res_id     <= 1'b0;
            res_zero   <= 1'b0;
        end else begin
            if (accept) begin
                last_grant <= grant_id;
                op_id      <= grant_id;
                op_a       <= grant_id ? req1_a  : req0_a;
                op_b       <= grant_id ? req1_b  : req0_b;
                op_code    <= grant_id ? req1_op : req0_op;
            end
            if (state == EXEC) begin
                res_data <= alu;
                res_id   <= op_id;
                res_zero <= (alu == '0);
            end
        end
    end

endmodule

// File: tb/tb_logic_arbiter.sv
// Directed bench for logic_arbiter: a 16-bit instance for the handshake/arbitration
// scenarios and an 8-bit instance for an opcode sweep against a reference function.
module tb_logic_arbiter;

    `define CHK(tag, obs, exp) begin checks++; assert ((obs) === (exp)) else begin errors++; $error("FAIL %s observed=%0h expected=%0h", tag, (obs), (exp)); end end

    int checks = 0;
    int errors = 0;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        r0v, r0rdy, r1v, r1rdy, rvalid, rready, rid, rzero;
    logic [15:0] r0a, r0b, r1a, r1b, rdata;
    logic [1:0]  r0o, r1o;

    logic        s0v, s0rdy, s1v, s1rdy, svalid, sready, sid, szero;
    logic [7:0]  s0a, s0b, s1a, s1b, sdata;
    logic [1:0]  s0o, s1o;
    int          hs8 = 0;

    logic [15:0] grants[$];
    logic [15:0] res_ids[$];
    logic [15:0] res_dat[$];

    logic_arbiter #(.WIDTH(16)) u16 (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(r0v), .req0_ready(r0rdy), .req0_a(r0a), .req0_b(r0b), .req0_op(r0o),
        .req1_valid(r1v), .req1_ready(r1rdy), .req1_a(r1a), .req1_b(r1b), .req1_op(r1o),
        .res_valid(rvalid), .res_ready(rready), .res_data(rdata), .res_id(rid), .res_zero(rzero)
    );

    logic_arbiter #(.WIDTH(8)) u8 (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(s0v), .req0_ready(s0rdy), .req0_a(s0a), .req0_b(s0b), .req0_op(s0o),
        .req1_valid(s1v), .req1_ready(s1rdy), .req1_a(s1a), .req1_b(s1b), .req1_op(s1o),
        .res_valid(svalid), .res_ready(sready), .res_data(sdata), .res_id(sid), .res_zero(szero)
    );

    always @(negedge clk) if (svalid && sready) hs8++;

    function automatic logic [7:0] ref8(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op);
        case (op)
            2'b00:   return a & b;
            2'b01:   return a | b;
            2'b10:   return a ^ b;
            default: return ~a;
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called #1 after a rising edge with the unit idle and res_ready high.
    task automatic run16(input bit id, input logic [15:0] a, input logic [15:0] b,
                         input logic [1:0] op, input logic [15:0] ed, input logic ez);
        int n;
        if (id) begin r1v = 1'b1; r1a = a; r1b = b; r1o = op; end
        else    begin r0v = 1'b1; r0a = a; r0b = b; r0o = op; end
        #1;
        n = 0;
        while (!(id ? r1rdy : r0rdy) && n < 10) begin step(); n++; end
        `CHK("grant", (id ? r1rdy : r0rdy), 1'b1)
        `CHK("ready_excl", (r0rdy & r1rdy), 1'b0)
        step();
        r0v = 1'b0; r1v = 1'b0;
        r0a = ~a; r0b = ~b; r1a = ~a; r1b = ~b; r0o = ~op; r1o = ~op;
        `CHK("exec_no_valid", rvalid, 1'b0)
        `CHK("exec_no_ready", (r0rdy | r1rdy), 1'b0)
        step();
        `CHK("res_valid", rvalid, 1'b1)
        `CHK("res_data", rdata, ed)
        `CHK("res_id", rid, id)
        `CHK("res_zero", rzero, ez)
        step();
        `CHK("back_idle", rvalid, 1'b0)
    endtask

    task automatic run8(input bit id, input logic [7:0] a, input logic [7:0] b, input logic [1:0] op);
        int n;
        logic [7:0] e;
        e = ref8(a, b, op);
        if (id) begin s1v = 1'b1; s1a = a; s1b = b; s1o = op; end
        else    begin s0v = 1'b1; s0a = a; s0b = b; s0o = op; end
        #1;
        n = 0;
        while (!(id ? s1rdy : s0rdy) && n < 10) begin step(); n++; end
        `CHK("w8_grant", (id ? s1rdy : s0rdy), 1'b1)
        step();
        s0v = 1'b0; s1v = 1'b0; s0a = ~a; s1a = ~a; s0o = ~op; s1o = ~op;
        step();
        `CHK("w8_valid", svalid, 1'b1)
        `CHK("w8_data", sdata, e)
        `CHK("w8_id", sid, id)
        `CHK("w8_zero", szero, (e == 8'h00))
        step();
    endtask

    initial begin
        int n;
        logic [15:0] held;
        r0v = 1'b1; r1v = 1'b1; r0a = '0; r0b = '0; r1a = '0; r1b = '0; r0o = '0; r1o = '0;
        s0v = 1'b0; s1v = 1'b0; s0a = '0; s0b = '0; s1a = '0; s1b = '0; s0o = '0; s1o = '0;
        rready = 1'b1; sready = 1'b1;
        rst_n = 1'b0;
        #3;
        `CHK("rst_valid", rvalid, 1'b0)
        `CHK("rst_data", rdata, 16'h0000)
        `CHK("rst_id", rid, 1'b0)
        `CHK("rst_zero", rzero, 1'b0)
        `CHK("rst_ready", (r0rdy | r1rdy), 1'b0)
        step();
        `CHK("rst_ready_clk", (r0rdy | r1rdy), 1'b0)

        // Both requesting continuously from reset release: grants alternate starting at 0.
        r0a = 16'h0001; r0b = 16'h0002; r0o = 2'b01;
        r1a = 16'h0100; r1b = 16'h0200; r1o = 2'b01;
        #2 rst_n = 1'b1;
        #1;
        for (int i = 0; i < 13; i++) begin
            checks++;
            if ((r0rdy & r1rdy) !== 1'b0) begin
                errors++;
                $error("FAIL %s observed=%0h expected=%0h", "rr_excl", (r0rdy & r1rdy), 1'b0);
            end
            if (r0rdy) grants.push_back(16'h0);
            if (r1rdy) grants.push_back(16'h1);
            if (rvalid && rready) begin res_ids.push_back({15'h0, rid}); res_dat.push_back(rdata); end
            step();
        end
        r0v = 1'b0; r1v = 1'b0;
        `CHK("rr_ngrants", (grants.size() >= 4), 1'b1)
        `CHK("rr_nres", (res_ids.size() >= 3), 1'b1)
        `CHK("rr_g0", grants[0], 16'h0)
        `CHK("rr_g1", grants[1], 16'h1)
        `CHK("rr_g2", grants[2], 16'h0)
        `CHK("rr_g3", grants[3], 16'h1)
        `CHK("rr_id0", res_ids[0], 16'h0)
        `CHK("rr_d0", res_dat[0], 16'h0003)
        `CHK("rr_id1", res_ids[1], 16'h1)
        `CHK("rr_d1", res_dat[1], 16'h0300)
        `CHK("rr_id2", res_ids[2], 16'h0)
        `CHK("rr_d2", res_dat[2], 16'h0003)
        repeat (4) step();

        run16(1'b0, 16'hF0F0, 16'hFF00, 2'b00, 16'hF000, 1'b0);
        run16(1'b1, 16'hAAAA, 16'hAAAA, 2'b10, 16'h0000, 1'b1);
        run16(1'b1, 16'h00FF, 16'h1234, 2'b11, 16'hFF00, 1'b0);
        run16(1'b0, 16'h5000, 16'h0A0A, 2'b01, 16'h5A0A, 1'b0);

        // Back-pressure: result held for 10 cycles while req0 keeps churning.
        rready = 1'b0;
        r0v = 1'b1; r0a = 16'h1234; r0b = 16'h00FF; r0o = 2'b10;
        #1;
        `CHK("bp_grant", r0rdy, 1'b1)
        step();
        r0a = 16'hFFFF;
        step();
        held = rdata;
        `CHK("bp_data", held, 16'h12CB)
        for (int i = 0; i < 10; i++) begin
            r0a = r0a + 16'h1111; r0b = ~r0b; r0o = r0o + 2'b01;
            #1;
            checks++;
            if ({rvalid, rdata} !== {1'b1, 16'h12CB}) begin
                errors++;
                $error("FAIL %s observed=%0h expected=%0h", "bp_hold", {rvalid, rdata}, {1'b1, 16'h12CB});
            end
            checks++;
            if ((r0rdy | r1rdy) !== 1'b0) begin
                errors++;
                $error("FAIL %s observed=%0h expected=%0h", "bp_no_ready", (r0rdy | r1rdy), 1'b0);
            end
            step();
        end
        r0v = 1'b0;
        rready = 1'b1;
        #1;
        `CHK("bp_last", rvalid, 1'b1)
        step();
        `CHK("bp_released", rvalid, 1'b0)
        `CHK("bp_kept_data", rdata, 16'h12CB)

        // Reset in EXEC: no result, outputs cleared at once, first tie to req0.
        r0v = 1'b1; r0a = 16'h0001; r0b = 16'h0001; r0o = 2'b01;
        #1;
        `CHK("rx_grant", r0rdy, 1'b1)
        step();
        r0v = 1'b1; r1v = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        `CHK("rx_valid", rvalid, 1'b0)
        `CHK("rx_data", rdata, 16'h0000)
        `CHK("rx_id_zero", {rid, rzero}, 2'b00)
        `CHK("rx_ready", (r0rdy | r1rdy), 1'b0)
        step();
        `CHK("rx_valid_held", rvalid, 1'b0)
        #3 rst_n = 1'b1;
        #1;
        `CHK("rx_tie0", r0rdy, 1'b1)
        `CHK("rx_tie1", r1rdy, 1'b0)
        r0v = 1'b0; r1v = 1'b0;
        step();
        `CHK("rx_no_result", rvalid, 1'b0)
        step();
        `CHK("rx_no_result2", rvalid, 1'b0)

        // 8-bit sweep: every opcode, random operands, alternating requesters.
        hs8 = 0;
        for (int i = 0; i < 16; i++) begin
            run8(i[0], 8'($urandom), 8'($urandom), i[2:1]);
        end
        run8(1'b0, 8'h3C, 8'hC3, 2'b00);
        n = hs8;
        `CHK("w8_handshakes", n, 17)

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
